// File: rtl/load_store_unit_if.sv
// Interface bundle for load_store_unit.
// Groups the CPU request/response handshake and the synchronous RAM port.
//   slave  : load_store_unit side (takes requests, drives RAM and responses)
//   master : CPU/RAM side (drives requests and ram_val)
// Signals:
//   req_valid/req_ready, req_write, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid, resp_rdata, resp_error
//   ram_write_enable, ram_addr, ram_set_val, ram_val
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        ram_write_enable;
  logic [31:0] ram_addr;
  logic [31:0] ram_set_val;
  logic [31:0] ram_val;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_val,
    output req_ready, resp_valid, resp_rdata, resp_error,
           ram_write_enable, ram_addr, ram_set_val
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, ram_val,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           ram_write_enable, ram_addr, ram_set_val
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide synchronous RAM
// (read data valid one cycle after the address). Handles byte/half/word loads
// with sign/zero extension, word stores in one write, sub-word stores by
// read-modify-write, and flags misaligned or reserved-size requests.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : load_store_unit_if.slave (request, response and RAM signals)
module load_store_unit (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LD_WAIT  = 3'd1;
  localparam logic [2:0] ST_MERGE = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] RESP     = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic [2:0]  r_state;
  logic        r_write;
  logic        r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_accept;
  logic        w_misalign;
  logic        w_word_store;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  always_comb begin
    w_misalign = 1'b0;
    case (bus.req_size)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = bus.req_addr[0];
      SZ_WORD: w_misalign = |bus.req_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_accept     = bus.req_valid && (r_state == IDLE) && !reset;
  // Word stores write straight through in the accept cycle.
  assign w_word_store = w_accept && bus.req_write && (bus.req_size == SZ_WORD) && !w_misalign;

  // Lane extraction for loads, from the captured address/size.
  always_comb begin
    w_byte      = bus.ram_val[{r_addr[1:0], 3'b000} +: 8];
    w_half      = r_addr[1] ? bus.ram_val[31:16] : bus.ram_val[15:0];
    w_load_data = bus.ram_val;
    case (r_size)
      SZ_BYTE: w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
      default: w_load_data = bus.ram_val;
    endcase
  end

  // Replace the addressed lane of the old word with the store data.
  always_comb begin
    w_merged = bus.ram_val;
    if (r_size == SZ_BYTE) begin
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end else if (r_addr[1]) begin
      w_merged[31:16] = r_wdata[15:0];
    end else begin
      w_merged[15:0] = r_wdata[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merge    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write    <= bus.req_write;
            r_unsigned <= bus.req_unsigned;
            r_size     <= bus.req_size;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_error    <= w_misalign;
            r_rdata    <= '0;
            if (w_misalign || w_word_store) begin
              r_state <= RESP;
            end else if (bus.req_write) begin
              r_state <= ST_MERGE;
            end else begin
              r_state <= LD_WAIT;
            end
          end
        end
        LD_WAIT: begin
          r_rdata <= w_load_data;
          r_state <= RESP;
        end
        ST_MERGE: begin
          r_merge <= w_merged;
          r_state <= ST_WRITE;
        end
        ST_WRITE: r_state <= RESP;
        RESP:     r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by reset so a reset in any state (including ST_WRITE)
  // takes effect in the same cycle.
  always_comb begin
    bus.req_ready        = (r_state == IDLE) && !reset;
    bus.resp_valid       = (r_state == RESP) && !reset;
    bus.resp_error       = bus.resp_valid && r_error;
    bus.resp_rdata       = bus.resp_valid ? r_rdata : '0;
    bus.ram_addr         = (r_state == IDLE) ? {bus.req_addr[31:2], 2'b00}
                                             : {r_addr[31:2], 2'b00};
    bus.ram_write_enable = w_word_store || ((r_state == ST_WRITE) && !reset);
    bus.ram_set_val      = w_word_store ? bus.req_wdata
                         : ((r_state == ST_WRITE) ? r_merge : '0);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  CPU memory request present.
REQ-005 req_ready  out  1  unit accepts a request this cycle; accept = req_valid && req_ready.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
REQ-008 req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-013 resp_error  out  1  misaligned or reserved-size request, valid with resp_valid.
REQ-014 ram_write_enable  out  1  RAM write strobe.
REQ-015 ram_addr  out  32  RAM byte address, always word-aligned ({addr[31:2],2'b00}).
REQ-016 ram_set_val  out  32  RAM write word.
REQ-017 ram_val  in  32  RAM read word, registered by RAM, valid the cycle after ram_addr is driven.

Function
REQ-018 RAM word layout SHALL be little-endian: byte offset k = ram_val[8k+7:8k]; half offset 0 = [15:0], offset 2 = [31:16].
REQ-019 FSM states SHALL be IDLE, LD_WAIT, ST_MERGE, ST_WRITE, RESP; req_ready = (state == IDLE).
REQ-020 In IDLE, ram_addr SHALL be driven combinationally from aligned req_addr; in all other states, from the captured address register.
REQ-021 On accept, req_write/size/unsigned/addr/wdata SHALL be captured; later input changes SHALL be ignored until the next accept.
REQ-022 Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 3 -> no RAM write, go to RESP with resp_error=1 and resp_rdata=0.
REQ-023 Load (accept cycle T): IDLE->LD_WAIT; at T+1 extract and extend the lane from ram_val into resp_rdata; RESP at T+2 with resp_valid=1.
REQ-024 Word store: ram_write_enable=1 and ram_set_val=req_wdata in accept cycle T, combinationally; RESP at T+1.
REQ-025 Byte/half store (read-modify-write): read at T; in ST_MERGE (T+1), replace the addressed lane of ram_val with req_wdata[7:0]/[15:0] into a merge register; in ST_WRITE (T+2), ram_write_enable=1 with ram_set_val=merge register; RESP at T+3.
REQ-026 ram_write_enable SHALL be 0 in every cycle not named in REQ-024/REQ-025.
REQ-027 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE; resp_valid=0 in all other states.
REQ-028 req_valid while req_ready=0 SHALL have no effect; the requester holds its request until accepted.
REQ-029 Sign extension SHALL replicate bit 7 (byte) or bit 15 (half) to bit 31; word loads pass through unchanged.
REQ-030 Throughput: loads 1 per 3 cycles, word stores 1 per 2, sub-word stores 1 per 4, errors 1 per 2.

Reset
REQ-031 While reset=1: state IDLE, req_ready=0, resp_valid=0, resp_error=0, resp_rdata=0, ram_write_enable=0, capture and merge registers 0.
REQ-032 reset=1 during any state, including ST_WRITE, SHALL suppress the pending RAM write and drop the request without a response.
REQ-033 req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 SW addr 0x4 data 0xDEADBEEF at T -> at T, ram_write_enable=1, ram_addr=0x4, ram_set_val=0xDEADBEEF; at T+1, resp_valid=1, resp_error=0.
REQ-035 Then LB addr 0x7 signed -> resp_rdata=0xFFFFFFDE at T+2; LBU addr 0x7 -> 0x000000DE; LH addr 0x6 signed -> 0xFFFFDEAD.
REQ-036 SB addr 0x5 data 0x12345677 -> at T+2, ram_write_enable=1, ram_addr=0x4, ram_set_val=0xDEAD77EF; resp_valid at T+3; subsequent LW 0x4 -> 0xDEAD77EF.
REQ-037 SH addr 0x3, and LW with req_size=3 -> at T+1, resp_valid=1, resp_error=1, resp_rdata=0; ram_write_enable never asserted.
REQ-038 SH addr 0x4 data 0x0000AAAA with reset pulsed during ST_WRITE -> no write; req_ready=1 after reset deasserts; LW 0x4 still returns 0xDEAD77EF.
REQ-039 req_valid held high with changing req_addr during LD_WAIT -> ignored; only one resp_valid per accept; the result reflects the captured address.
